// File: rtl/main_decoder.sv
// RV32I main control decoder: opcode -> datapath controls, registered with one-cycle latency.
// Optional build macro MAIN_DECODER_JALR_EN adds the jalr (op=103) decode row.
module main_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  output logic       branch,
  output logic       jump,
  output logic       mem_write,
  output logic       alu_src,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [1:0] alu_op
);

  localparam int unsigned OP_W   = 7;
  localparam int unsigned CTRL_W = 11;

  localparam logic [OP_W-1:0] OP_LW   = OP_W'(7'b0000011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(7'b0100011);
  localparam logic [OP_W-1:0] OP_R    = OP_W'(7'b0110011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(7'b1100011);
  localparam logic [OP_W-1:0] OP_I    = OP_W'(7'b0010011);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(7'b1101111);
`ifdef MAIN_DECODER_JALR_EN
  localparam logic [OP_W-1:0] OP_JALR = OP_W'(7'b1100111);
`endif

  // Field order mirrors the decode table so rows read left to right.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] imm_src;
    logic       alu_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       jump;
  } ctrl_t;

  ctrl_t dec_c;
  ctrl_t ctrl_q;

  // Opcode decode; unknown opcodes (and X/Z) fall to the safe all-zero row.
  always_comb begin
    dec_c = '0;
    case (op)
      OP_LW:   dec_c = ctrl_t'(CTRL_W'(11'b1_00_1_0_01_0_00_0));
      OP_SW:   dec_c = ctrl_t'(CTRL_W'(11'b0_01_1_1_00_0_00_0));
      OP_R:    dec_c = ctrl_t'(CTRL_W'(11'b1_00_0_0_00_0_10_0));
      OP_BEQ:  dec_c = ctrl_t'(CTRL_W'(11'b0_10_0_0_00_1_01_0));
      OP_I:    dec_c = ctrl_t'(CTRL_W'(11'b1_00_1_0_00_0_10_0));
      OP_JAL:  dec_c = ctrl_t'(CTRL_W'(11'b1_11_0_0_10_0_00_1));
`ifdef MAIN_DECODER_JALR_EN
      OP_JALR: dec_c = ctrl_t'(CTRL_W'(11'b1_00_1_0_10_0_00_1));
`endif
      default: dec_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= dec_c;
    end
  end

  assign reg_write  = ctrl_q.reg_write;
  assign imm_src    = ctrl_q.imm_src;
  assign alu_src    = ctrl_q.alu_src;
  assign mem_write  = ctrl_q.mem_write;
  assign result_src = ctrl_q.result_src;
  assign branch     = ctrl_q.branch;
  assign alu_op     = ctrl_q.alu_op;
  assign jump       = ctrl_q.jump;

endmodule

// File: tb/tb_main_decoder.sv
// Directed and random-invariant bench for main_decoder.
module tb_main_decoder;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic       branch, jump, mem_write, alu_src, reg_write;
  logic [1:0] result_src, imm_src, alu_op;

  int checks;
  int errors;

  // Packed as reg_write, imm_src, alu_src, mem_write, result_src, branch, alu_op, jump.
  localparam logic [10:0] ROW_ZERO = 11'b0_00_0_0_00_0_00_0;
  localparam logic [10:0] ROW_LW   = 11'b1_00_1_0_01_0_00_0;
  localparam logic [10:0] ROW_SW   = 11'b0_01_1_1_00_0_00_0;
  localparam logic [10:0] ROW_R    = 11'b1_00_0_0_00_0_10_0;
  localparam logic [10:0] ROW_BEQ  = 11'b0_10_0_0_00_1_01_0;
  localparam logic [10:0] ROW_I    = 11'b1_00_1_0_00_0_10_0;
  localparam logic [10:0] ROW_JAL  = 11'b1_11_0_0_10_0_00_1;
`ifdef MAIN_DECODER_JALR_EN
  localparam logic [10:0] ROW_JALR = 11'b1_00_1_0_10_0_00_1;
`else
  localparam logic [10:0] ROW_JALR = 11'b0_00_0_0_00_0_00_0;
`endif

  main_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .branch     (branch),
    .jump       (jump),
    .mem_write  (mem_write),
    .alu_src    (alu_src),
    .reg_write  (reg_write),
    .result_src (result_src),
    .imm_src    (imm_src),
    .alu_op     (alu_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] got_row();
    return {reg_write, imm_src, alu_src, mem_write, result_src, branch, alu_op, jump};
  endfunction

  task automatic test_reset();
    logic [10:0] got;
    rst = 1'b1;
    op  = 7'd51;
    #12;
    got = got_row();
    checks++;
    if (got !== ROW_ZERO) begin
      errors++;
      $display("FAIL reset_initial: got %b expected %b", got, ROW_ZERO);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    got = got_row();
    checks++;
    if (got !== ROW_R) begin
      errors++;
      $display("FAIL reset_release_rtype: got %b expected %b", got, ROW_R);
    end
    // Assert reset mid-cycle; outputs must clear before the next edge.
    #2 rst = 1'b1;
    #1;
    got = got_row();
    checks++;
    if (got !== ROW_ZERO) begin
      errors++;
      $display("FAIL reset_async_clear: got %b expected %b", got, ROW_ZERO);
    end
    @(posedge clk); #1;
    got = got_row();
    checks++;
    if (got !== ROW_ZERO) begin
      errors++;
      $display("FAIL reset_hold: got %b expected %b", got, ROW_ZERO);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    got = got_row();
    checks++;
    if (got !== ROW_R) begin
      errors++;
      $display("FAIL reset_second_release: got %b expected %b", got, ROW_R);
    end
  endtask

  task automatic test_opcode_sweep();
    logic [6:0]  ops  [8] = '{7'd0, 7'd19, 7'd3, 7'd35, 7'd4, 7'd51, 7'd99, 7'd111};
    logic [10:0] rows [8] = '{ROW_ZERO, ROW_I, ROW_LW, ROW_SW, ROW_ZERO, ROW_R, ROW_BEQ, ROW_JAL};
    logic [10:0] got;
    for (int i = 0; i < 8; i++) begin
      op = ops[i];
      @(posedge clk); #1;
      got = got_row();
      checks++;
      if (got !== rows[i]) begin
        errors++;
        $display("FAIL sweep_op%0d: got %b expected %b", ops[i], got, rows[i]);
      end
    end
  endtask

  task automatic test_branch_jump();
    op = 7'd99;
    @(posedge clk); #1;
    checks++;
    if ({branch, imm_src, alu_op, reg_write, jump} !== 7'b1_10_01_0_0) begin
      errors++;
      $display("FAIL beq_fields: got %b expected %b",
               {branch, imm_src, alu_op, reg_write, jump}, 7'b1_10_01_0_0);
    end
    op = 7'd111;
    @(posedge clk); #1;
    checks++;
    if ({jump, reg_write, imm_src, result_src, branch} !== 7'b1_1_11_10_0) begin
      errors++;
      $display("FAIL jal_fields: got %b expected %b",
               {jump, reg_write, imm_src, result_src, branch}, 7'b1_1_11_10_0);
    end
  endtask

  task automatic test_latency();
    logic [10:0] got;
    op = 7'd19;
    @(posedge clk); #1;
    got = got_row();
    checks++;
    if (got !== ROW_I) begin
      errors++;
      $display("FAIL latency_itype: got %b expected %b", got, ROW_I);
    end
    op = 7'd35;
    #3;
    got = got_row();
    checks++;
    if (got !== ROW_I) begin
      errors++;
      $display("FAIL latency_hold: got %b expected %b", got, ROW_I);
    end
    @(posedge clk); #1;
    got = got_row();
    checks++;
    if (got !== ROW_SW) begin
      errors++;
      $display("FAIL latency_sw: got %b expected %b", got, ROW_SW);
    end
  endtask

  task automatic test_jalr();
    logic [10:0] got;
    op = 7'd103;
    @(posedge clk); #1;
    got = got_row();
    checks++;
    if (got !== ROW_JALR) begin
      errors++;
      $display("FAIL jalr_row: got %b expected %b", got, ROW_JALR);
    end
  endtask

  task automatic test_random_invariants();
    logic [10:0] got;
    logic        listed;
    for (int i = 0; i < 300; i++) begin
      op = 7'($urandom_range(0, 127));
      @(posedge clk); #1;
      got = got_row();
      checks++;
      if (branch && jump) begin
        errors++;
        $display("FAIL inv_branch_jump op%0d: got branch=%b jump=%b expected not both 1", op, branch, jump);
      end
      checks++;
      if (mem_write && reg_write) begin
        errors++;
        $display("FAIL inv_memw_regw op%0d: got mem_write=%b reg_write=%b expected not both 1",
                 op, mem_write, reg_write);
      end
      listed = op inside {7'd3, 7'd35, 7'd51, 7'd99, 7'd19, 7'd111};
`ifdef MAIN_DECODER_JALR_EN
      listed = listed || (op == 7'd103);
`endif
      if (!listed) begin
        checks++;
        if (got !== ROW_ZERO) begin
          errors++;
          $display("FAIL unlisted_op%0d: got %b expected %b", op, got, ROW_ZERO);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    op  = 7'd0;
    test_reset();
    test_opcode_sweep();
    test_branch_jump();
    test_latency();
    test_jalr();
    test_random_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/main_decoder.md
Name: main_decoder

Overview:
- Main control decoder for the single-cycle RISC-V core.
- Decodes the 7-bit instruction opcode into datapath control signals: branch, jump, memory write, ALU source, register write, result mux select, immediate format select and ALU operation class.
- Outputs are registered: one rising-clock latency.
- Feeds the ALU decoder (via alu_op), the immediate extender, the result mux, the register file and data memory.

Parameters:
- None. Opcode encodings and the control table are fixed by the RV32I base ISA.

Ports:
- clk  input  1  system clock; all outputs update on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all outputs.
- op  input  7  instruction opcode field, instr[6:0].
- branch  output  1  conditional branch instruction (beq).
- jump  output  1  unconditional jump (jal).
- mem_write  output  1  data-memory write enable.
- alu_src  output  1  ALU operand B select: 0 = register rs2, 1 = immediate.
- reg_write  output  1  register-file write enable.
- result_src  output  2  writeback select: 00 = ALU result, 01 = memory read data, 10 = PC+4, 11 = unused.
- imm_src  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- alu_op  output  2  ALU class: 00 = add, 01 = subtract/compare, 10 = decode by funct3/funct7, 11 = unused.

Behaviour:
- Reset:
  - rst high clears every output to 0 immediately, without waiting for a clock edge.
  - Outputs stay 0 while rst is high.
  - After rst falls, the first rising clk edge loads the decode of the current op.
- Timing:
  - A combinational decode of op is captured into output registers on each rising clk.
  - Latency is exactly 1 cycle; outputs are glitch-free and hold between edges.
- Decode table, field order reg_write, imm_src, alu_src, mem_write, result_src, branch, alu_op, jump:
  - op=3 (0000011, lw): 1, 00, 1, 0, 01, 0, 00, 0
  - op=35 (0100011, sw): 0, 01, 1, 1, 00, 0, 00, 0
  - op=51 (0110011, R-type): 1, 00, 0, 0, 00, 0, 10, 0
  - op=99 (1100011, beq): 0, 10, 0, 0, 00, 1, 01, 0
  - op=19 (0010011, I-type ALU): 1, 00, 1, 0, 00, 0, 10, 0
  - op=111 (1101111, jal): 1, 11, 0, 0, 10, 0, 00, 1
- Don't-care fields from the textbook table (sw result_src, R-type imm_src, jal alu_src) are driven to 0 for determinism.
- Any other opcode, including 0 and 4, decodes to all zeros. This default is safe: no register or memory write, no branch, no jump.
- An op containing X or Z bits decodes to all zeros, through the default branch.
- At most one of branch and jump is ever 1.
- mem_write=1 implies reg_write=0.

Optional Feature:
- Macro: MAIN_DECODER_JALR_EN.
- Defined: op=103 (1100111, jalr) decodes to reg_write=1, imm_src=00, alu_src=1, mem_write=0, result_src=10, branch=0, alu_op=00, jump=1. The ALU computes rs1+imm as the jump target.
- Undefined: op=103 takes the all-zero default.
- All other rows are identical in both builds.

Test Plan:
- Reset: assert rst mid-cycle while op=51 and outputs are nonzero -> all outputs read 0 before the next clk edge; release rst, op=51 -> after 1 rising edge, reg_write=1, alu_op=10, all others 0.
- Opcode sweep, each held 10 time units: op = 0, 19, 3, 35, 4, 51, 99, 111 -> table values one edge after each change.
  - op=0 and op=4 -> all zero.
  - op=3 -> reg_write=1, alu_src=1, result_src=01.
  - op=35 -> imm_src=01, alu_src=1, mem_write=1.
- Branch/jump: op=99 -> branch=1, imm_src=10, alu_op=01, reg_write=0; op=111 -> jump=1, reg_write=1, imm_src=11, result_src=10.
- Latency: change op from 19 to 35 just after a rising edge -> outputs still show the I-type row until the next rising edge, then the sw row.
- Feature: op=103 -> with MAIN_DECODER_JALR_EN, jump=1, alu_src=1, result_src=10, reg_write=1; without it, all outputs 0.
- Invariants checked every cycle over random op values: never branch=1 together with jump=1; never mem_write=1 together with reg_write=1; unlisted opcodes give all zeros.
